// File: rtl/feature_map_capture_if.sv
// Bundle of the accelerator-side, reader-side and status signals of
// feature_map_capture. The checksum member exists only when
// CAPTURE_CHECKSUM_EN is defined. master = the environment driving the
// accelerator/reader side; slave = the capture block.
interface feature_map_capture_if #(
  parameter int OUTPUT_COUNT = 196,
  parameter int DATA_W       = 8
);
  localparam int CNT_W = $clog2(OUTPUT_COUNT + 1);

  // control and accelerator stream
  logic              start;
  logic              data_valid_in;
  logic [DATA_W-1:0] pixel_in;
  logic              layer_done;

  // readout handshake
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // status
  logic              capture_done;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  count;
`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  modport master (
    output start, data_valid_in, pixel_in, layer_done, rd_ready,
    input  rd_valid, rd_data, capture_done, overflow, underflow, count
`ifdef CAPTURE_CHECKSUM_EN
    , input checksum
`endif
  );

  modport slave (
    input  start, data_valid_in, pixel_in, layer_done, rd_ready,
    output rd_valid, rd_data, capture_done, overflow, underflow, count
`ifdef CAPTURE_CHECKSUM_EN
    , output checksum
`endif
  );

endinterface : feature_map_capture_if

// File: rtl/feature_map_capture.sv
// feature_map_capture: records one layer of accelerator output pixels into a
// local buffer, then replays them in arrival order over a valid/ready port.
// Out-of-range strobes raise a sticky overflow, a short layer raises a
// sticky underflow. Optional feature: define CAPTURE_CHECKSUM_EN to add a
// 16-bit running sum of the stored (sign-extended) pixels.
module feature_map_capture #(
  parameter int OUTPUT_COUNT = 196,
  parameter int DATA_W       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  feature_map_capture_if.slave bus
);

  localparam int CNT_W = $clog2(OUTPUT_COUNT + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OUTPUT_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  rd_ptr;
  logic              overflow_q;
  logic              underflow_q;
  logic              capture_done_q;
`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0]       checksum_q;
`endif

  logic [DATA_W-1:0] mem [OUTPUT_COUNT];

  logic              store;       // pixel accepted into mem on this edge
  logic              take;        // readout word transferred on this edge
  logic              rd_valid_c;
  logic [CNT_W-1:0]  count_next;  // count as it will be after this edge
  logic [CNT_W-1:0]  rd_ptr_next;

  // Decode this cycle's events; start pre-empts everything.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    store       = 1'b0;
    take        = 1'b0;
    rd_valid_c  = 1'b0;
    if (state == DRAIN && rd_ptr < count_q) rd_valid_c = 1'b1;
    if (!bus.start) begin
      store = (state == CAPTURE) && bus.data_valid_in && (count_q < FULL);
      take  = rd_valid_c && bus.rd_ready;
    end
    count_next  = count_q + CNT_W'(store);
    rd_ptr_next = rd_ptr + CNT_W'(1);
  end

  // Pixel buffer write port; the read side is purely combinational.
  // NOTE: the buffer is deliberately left out of reset -- count bounds every
  // read, so stale contents are never observed and no reset fan-out is spent.
  always_ff @(posedge clk) begin
    if (store) mem[count_q] <= bus.pixel_in;
  end

  // Capture/drain FSM with its counters and sticky flags.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count_q        <= '0;
      rd_ptr         <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      capture_done_q <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
      checksum_q     <= '0;
`endif
    end else if (bus.start) begin
      // arm or abort-and-rearm from any state
      state          <= CAPTURE;
      count_q        <= '0;
      rd_ptr         <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      capture_done_q <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
      checksum_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: ;

        CAPTURE: begin
          count_q <= count_next;
`ifdef CAPTURE_CHECKSUM_EN
          if (store) checksum_q <= checksum_q + 16'($signed(bus.pixel_in));
`endif
          if (bus.data_valid_in && count_q == FULL) overflow_q <= 1'b1;
          // a pixel on the layer_done edge is already in count_next
          if (bus.layer_done) begin
            state       <= DRAIN;
            rd_ptr      <= '0;
            underflow_q <= (count_next < FULL);
          end
        end

        DRAIN: begin
          if (count_q == '0) begin
            state          <= DONE;
            capture_done_q <= 1'b1;
          end else if (take) begin
            rd_ptr <= rd_ptr_next;
            if (rd_ptr_next == count_q) begin
              state          <= DONE;
              capture_done_q <= 1'b1;
            end
          end
        end

        DONE: ;

        default: state <= IDLE;
      endcase
    end
  end

  // Outputs: rd_data follows rd_ptr directly, so it cannot change while a
  // word is stalled, and reads as zero whenever no word is offered.
  assign bus.rd_valid     = rd_valid_c;
  assign bus.rd_data      = rd_valid_c ? mem[rd_ptr] : '0;
  assign bus.capture_done = capture_done_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.count        = count_q;
`ifdef CAPTURE_CHECKSUM_EN
  assign bus.checksum     = checksum_q;
`endif

endmodule : feature_map_capture

// File: tb/tb_feature_map_capture.sv
// Directed self-checking bench for feature_map_capture. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_feature_map_capture;

  localparam int OC = 196;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  feature_map_capture_if #(.OUTPUT_COUNT(OC), .DATA_W(DW)) bus ();

  feature_map_capture #(.OUTPUT_COUNT(OC), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // pixel value patterns by mode
  function automatic logic [7:0] pix(input int mode, input int i);
    case (mode)
      0:       pix = 8'(i % 128);
      1:       pix = 8'(i);
      2:       pix = 8'(i * 3 + 5);
      default: pix = 8'hFF;
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  // n strobes; optionally the last one shares its edge with layer_done
  task automatic push(input int n, input int mode, input bit last_with_done);
    for (int i = 0; i < n; i++) begin
      bus.data_valid_in = 1'b1;
      bus.pixel_in      = pix(mode, i);
      bus.layer_done    = last_with_done && (i == n - 1);
      cyc();
    end
    bus.data_valid_in = 1'b0;
    bus.layer_done    = 1'b0;
  endtask

  task automatic end_layer();
    bus.layer_done = 1'b1;
    cyc();
    bus.layer_done = 1'b0;
  endtask

  // Drain n_exp words, checking order, stall stability and the DONE state.
  task automatic drain(input int n_exp, input int mode, input bit toggle);
    int         idx = 0;
    int         cyc_n = 0;
    bit         stalled = 1'b0;
    logic [7:0] held = '0;
    while (idx < n_exp && cyc_n < 4 * OC) begin
      bus.rd_ready = toggle ? (cyc_n % 2 == 0) : 1'b1;
      if (!bus.rd_valid) begin
        check("rd_valid_during_drain", bus.rd_valid, 1);
        break;
      end
      check("rd_data", bus.rd_data, pix(mode, idx));
      if (stalled) check("rd_data_hold", bus.rd_data, held);
      if (bus.rd_ready) begin
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = bus.rd_data;
      end
      cyc();
      cyc_n++;
    end
    bus.rd_ready = 1'b0;
    check("drain_words", idx, n_exp);
    check("done_rd_valid", bus.rd_valid, 0);
    check("capture_done", bus.capture_done, 1);
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.data_valid_in = 1'b0;
    bus.pixel_in      = '0;
    bus.layer_done    = 1'b0;
    bus.rd_ready      = 1'b0;

    // reset state
    #12;
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_capture_done", bus.capture_done, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_underflow", bus.underflow, 0);
    check("rst_count", bus.count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // strobes ignored in IDLE
    push(3, 0, 1'b0);
    check("idle_ignore_count", bus.count, 0);

    // nominal layer
    do_start();
    push(OC, 0, 1'b0);
    check("nom_count", bus.count, OC);
    end_layer();
    check("nom_first_valid", bus.rd_valid, 1);
    check("nom_overflow", bus.overflow, 0);
    check("nom_underflow", bus.underflow, 0);
    drain(OC, 0, 1'b0);
    push(2, 0, 1'b1);
    check("done_ignore_count", bus.count, OC);
    check("done_hold", bus.capture_done, 1);

    // overflow: 200 strobes, last 4 discarded
    do_start();
    check("restart_count", bus.count, 0);
    check("restart_done", bus.capture_done, 0);
    push(OC + 4, 1, 1'b0);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_count", bus.count, OC);
    end_layer();
    check("ovf_underflow", bus.underflow, 0);
    drain(OC, 1, 1'b0);

    // underflow: 150 strobes
    do_start();
    push(150, 2, 1'b0);
    end_layer();
    check("udf_flag", bus.underflow, 1);
    check("udf_count", bus.count, 150);
    drain(150, 2, 1'b0);

    // backpressure; last strobe on the layer_done edge still counted
    do_start();
    push(OC, 2, 1'b1);
    check("simul_count", bus.count, OC);
    check("simul_underflow", bus.underflow, 0);
    drain(OC, 2, 1'b1);

    // empty layer goes to DONE one edge after entering DRAIN
    do_start();
    end_layer();
    check("empty_underflow", bus.underflow, 1);
    check("empty_rd_valid", bus.rd_valid, 0);
    check("empty_not_done_yet", bus.capture_done, 0);
    cyc();
    check("empty_done", bus.capture_done, 1);

    // start mid-DRAIN wins over a concurrent strobe and transfer
    do_start();
    push(OC + 4, 1, 1'b0);
    end_layer();
    bus.rd_ready = 1'b1;
    repeat (5) cyc();
    bus.rd_ready = 1'b0;
    check("mid_rd_data", bus.rd_data, pix(1, 5));
    bus.rd_ready      = 1'b1;
    bus.data_valid_in = 1'b1;
    bus.pixel_in      = 8'h55;
    do_start();
    bus.rd_ready      = 1'b0;
    bus.data_valid_in = 1'b0;
    check("abort_count", bus.count, 0);
    check("abort_overflow", bus.overflow, 0);
    check("abort_underflow", bus.underflow, 0);
    check("abort_rd_valid", bus.rd_valid, 0);
    check("abort_done", bus.capture_done, 0);
    push(4, 1, 1'b0);
    check("recapture_count", bus.count, 4);

    // asynchronous reset mid-DRAIN
    end_layer();
    bus.rd_ready = 1'b1;
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd_valid", bus.rd_valid, 0);
    check("arst_rd_data", bus.rd_data, 0);
    check("arst_count", bus.count, 0);
    check("arst_underflow", bus.underflow, 0);
    check("arst_done", bus.capture_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rd_ready = 1'b0;
    cyc();
    check("post_rst_rd_valid", bus.rd_valid, 0);
    check("post_rst_done", bus.capture_done, 0);

`ifdef CAPTURE_CHECKSUM_EN
    // 196 x (-1) = -196 = 0xFF3C; last pixel shares the layer_done edge
    do_start();
    check("csum_clear", bus.checksum, 0);
    push(OC, 3, 1'b1);
    check("csum_value", bus.checksum, 16'hFF3C);
    check("csum_count", bus.count, OC);
    drain(OC, 3, 1'b0);
    check("csum_hold", bus.checksum, 16'hFF3C);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_feature_map_capture
